// File: rtl/or4_event_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | or4_event_capture                                                          |
// | Synchronized, sticky, acknowledged event capture for four request lines.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module or4_event_capture #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RSTB,
  input  logic       IN1,
  input  logic       IN2,
  input  logic       IN3,
  input  logic       IN4,
  input  logic       ACK,
  output logic       Q,
  output logic       VALID,
  output logic [1:0] ID,
  output logic       OVR
);

  localparam logic [3:0] c_HOLD_LOAD = (HOLD_CYCLES == 0) ? 4'd0 : 4'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  logic [3:0] w_in;
  logic [3:0] w_edge;
  logic [3:0] w_clr;
  logic [3:0] w_pend_nxt;
  logic [1:0] w_prio;
  logic [1:0] w_id_nxt;
  logic [3:0] w_cnt_nxt;
  logic       w_accept;
  state_t     w_state_nxt;

  state_t     r_state;
  logic [3:0] r_pending;
  logic [3:0] r_cnt;
  logic [1:0] r_id;
  logic       r_valid;
  logic       r_q;
  logic       r_ovr;

  assign w_in = {IN4, IN3, IN2, IN1};

  for (genvar n = 0; n < 4; n++) begin : g_src
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
        r_sync <= '0;
        r_prev <= 1'b0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], w_in[n]};
        r_prev <= r_sync[SYNC_STAGES-1];
      end
    end

    assign w_edge[n] = r_sync[SYNC_STAGES-1] & ~r_prev;
  end

  // Lowest set index wins.
  always_comb begin
    w_prio = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (r_pending[i]) w_prio = 2'(i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_id_nxt    = r_id;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|r_pending) begin
          w_state_nxt = ST_PRESENT;
          w_id_nxt    = w_prio;
        end
      end
      ST_PRESENT: begin
        if (ACK) begin
          w_accept = 1'b1;
          if (HOLD_CYCLES == 0) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = c_HOLD_LOAD;
          end
        end
      end
      ST_HOLD: begin
        if (r_cnt == 4'd0) w_state_nxt = ST_IDLE;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A new edge on the source being accepted re-sets its bit (set wins).
  assign w_clr      = w_accept ? (4'b0001 << r_id) : 4'b0000;
  assign w_pend_nxt = (r_pending & ~w_clr) | w_edge;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_state   <= ST_IDLE;
      r_pending <= 4'b0000;
      r_cnt     <= 4'd0;
      r_id      <= 2'd0;
      r_valid   <= 1'b0;
      r_q       <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pend_nxt;
      r_cnt     <= w_cnt_nxt;
      r_id      <= w_id_nxt;
      r_valid   <= (w_state_nxt == ST_PRESENT);
      r_q       <= |w_pend_nxt;
      r_ovr     <= |(w_edge & r_pending & ~w_clr);
    end
  end

  assign Q     = r_q;
  assign VALID = r_valid;
  assign ID    = r_id;
  assign OVR   = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_or4_event_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_or4_event_capture                                                       |
// | Scoreboard bench: HOLD_CYCLES=4 instance (A) and HOLD_CYCLES=0 instance (B)|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_or4_event_capture;

  logic       CLK = 1'b0;
  logic       RSTB;
  logic [3:0] in_a, in_b;
  logic       ack_a, ack_b;
  logic       q_a, valid_a, ovr_a;
  logic       q_b, valid_b, ovr_b;
  logic [1:0] id_a, id_b;

  int n_cmp = 0;
  int n_err = 0;
  int q_exp_a[$];
  int q_exp_b[$];
  int exp_a, exp_b;
  int n;

  always #5 CLK = ~CLK;

  or4_event_capture #(.SYNC_STAGES(2), .HOLD_CYCLES(4)) u_dut_a (
    .CLK(CLK), .RSTB(RSTB),
    .IN1(in_a[0]), .IN2(in_a[1]), .IN3(in_a[2]), .IN4(in_a[3]),
    .ACK(ack_a), .Q(q_a), .VALID(valid_a), .ID(id_a), .OVR(ovr_a)
  );

  or4_event_capture #(.SYNC_STAGES(2), .HOLD_CYCLES(0)) u_dut_b (
    .CLK(CLK), .RSTB(RSTB),
    .IN1(in_b[0]), .IN2(in_b[1]), .IN3(in_b[2]), .IN4(in_b[3]),
    .ACK(ack_b), .Q(q_b), .VALID(valid_b), .ID(id_b), .OVR(ovr_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_valid_a(input string tag, output int cnt);
    cnt = 0;
    while (!valid_a && cnt < 30) begin
      tick();
      cnt++;
    end
    chk(tag, valid_a, 1);
  endtask

  // Accepts happen on the next rising edge; pop the expected ID then.
  always @(negedge CLK) begin
    if (RSTB && valid_a && ack_a) begin
      if (q_exp_a.size() == 0) chk("unexpected_grant_a", q_exp_a.size(), 1);
      else begin
        exp_a = q_exp_a.pop_front();
        chk("grant_id_a", id_a, exp_a);
      end
    end
    if (RSTB && valid_b && ack_b) begin
      if (q_exp_b.size() == 0) chk("unexpected_grant_b", q_exp_b.size(), 1);
      else begin
        exp_b = q_exp_b.pop_front();
        chk("grant_id_b", id_b, exp_b);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTB  = 1'b0;
    in_a  = 4'hF;
    in_b  = 4'h0;
    ack_a = 1'b0;
    ack_b = 1'b1;

    // Reset with all inputs high, then release
    repeat (3) tick();
    chk("rst_q", q_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_id", id_a, 0);
    chk("rst_ovr", ovr_a, 0);
    RSTB = 1'b1;
    tick();
    chk("t1_q_k0", q_a, 0);
    tick();
    chk("t1_q_k1", q_a, 0);
    tick();
    chk("t1_q_k2", q_a, 1);
    chk("t1_valid_k2", valid_a, 0);
    tick();
    chk("t1_valid_k3", valid_a, 1);
    chk("t1_id_k3", id_a, 0);
    q_exp_a = '{0, 1, 2, 3};
    in_a  = 4'h0;
    ack_a = 1'b1;
    n = 0;
    while (q_exp_a.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    chk("t1_drain", q_exp_a.size(), 0);
    tick();
    chk("t1_q_empty", q_a, 0);
    ack_a = 1'b0;
    repeat (8) tick();

    // Priority and hold gap
    ack_a = 1'b1;
    q_exp_a.push_back(1);
    q_exp_a.push_back(2);
    in_a = 4'b0110;
    tick();
    tick();
    in_a = 4'b0000;
    wait_valid_a("t2_valid1", n);
    chk("t2_id1", id_a, 1);
    chk("t2_q1", q_a, 1);
    tick();
    chk("t2_valid_drop", valid_a, 0);
    chk("t2_q_mid", q_a, 1);
    n = 0;
    while (!valid_a && n < 30) begin
      tick();
      n++;
    end
    chk("t2_gap", n, 5);
    chk("t2_id2", id_a, 2);
    tick();
    chk("t2_q_fall", q_a, 0);
    chk("t2_valid_end", valid_a, 0);
    ack_a = 1'b0;
    repeat (8) tick();

    // Collision of a new IN1 edge with the accept of ID 0
    q_exp_a.push_back(0);
    in_a = 4'b0001;
    tick();
    tick();
    in_a = 4'b0000;
    wait_valid_a("t3_valid1", n);
    chk("t3_id1", id_a, 0);
    repeat (3) tick();
    in_a = 4'b0001;
    tick();
    tick();
    ack_a = 1'b1;
    tick();
    chk("t3_valid_drop", valid_a, 0);
    chk("t3_ovr", ovr_a, 0);
    chk("t3_q_kept", q_a, 1);
    in_a  = 4'b0000;
    ack_a = 1'b0;
    q_exp_a.push_back(0);
    n = 0;
    while (!valid_a && n < 30) begin
      tick();
      n++;
    end
    chk("t3_gap", n, 5);
    chk("t3_id2", id_a, 0);
    ack_a = 1'b1;
    tick();
    ack_a = 1'b0;
    chk("t3_valid_end", valid_a, 0);
    chk("t3_q_end", q_a, 0);
    repeat (8) tick();

    // Overrun: second IN4 edge while pending
    for (int i = 0; i < 12; i++) begin
      in_a = (i == 0 || i == 1 || i == 6 || i == 7) ? 4'b1000 : 4'b0000;
      tick();
      chk("t4_ovr", ovr_a, (i == 8) ? 1 : 0);
    end
    chk("t4_valid", valid_a, 1);
    chk("t4_id", id_a, 3);
    q_exp_a.push_back(3);
    ack_a = 1'b1;
    tick();
    ack_a = 1'b0;
    chk("t4_q_clear", q_a, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t4_no_second", valid_a, 0);
    end

    // HOLD_CYCLES=0 instance, ACK tied high, all sources at once
    q_exp_b = '{0, 1, 2, 3};
    in_b = 4'hF;
    tick();
    tick();
    in_b = 4'h0;
    n = 0;
    while (!valid_b && n < 30) begin
      tick();
      n++;
    end
    chk("t5_valid", valid_b, 1);
    for (int i = 0; i < 7; i++) begin
      chk("t5_valid_seq", valid_b, (i % 2 == 0) ? 1 : 0);
      if (i % 2 == 0) chk("t5_id", id_b, i / 2);
      tick();
    end
    chk("t5_drain", q_exp_b.size(), 0);
    repeat (4) tick();

    // Asynchronous reset while presenting ID 2
    in_a = 4'b0100;
    tick();
    tick();
    in_a = 4'b0000;
    wait_valid_a("t6_valid", n);
    chk("t6_id", id_a, 2);
    #3;
    RSTB = 1'b0;
    #1;
    chk("t6_valid_async", valid_a, 0);
    chk("t6_q_async", q_a, 0);
    chk("t6_id_async", id_a, 0);
    tick();
    tick();
    RSTB = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t6_no_stale", valid_a, 0);
    end
    chk("t6_q_after", q_a, 0);

    chk("end_queue_a", q_exp_a.size(), 0);
    chk("end_queue_b", q_exp_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
